// File: rtl/reg_bank_scan_reader.sv
// Walks a register bank's combinational read port from index 0 to DEPTH-1 and streams each word out on a valid/ready interface.
// Optional build macro SCAN_SKIP_ZERO_EN: zero (empty) entries are skipped instead of presented.
module reg_bank_scan_reader #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    output logic [IDX_W-1:0] Rd_Index,
    input  logic [WIDTH-1:0] Rd_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic [IDX_W-1:0] Out_Index,
    output logic             Busy,
    output logic             Done,
    output logic [IDX_W:0]   Word_Count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e           state_q,      state_d;
    logic [IDX_W-1:0] rd_index_q,   rd_index_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [IDX_W-1:0] out_index_q,  out_index_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic [IDX_W:0]   word_count_q, word_count_d;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_d      = state_q;
        rd_index_d   = rd_index_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        word_count_d = word_count_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    word_count_d = '0;
                    rd_index_d   = '0;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
`ifdef SCAN_SKIP_ZERO_EN
                if (Rd_Data == '0) begin
                    if (rd_index_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_index_d = rd_index_q + IDX_ONE;
                        state_d    = S_FETCH;
                    end
                end else begin
                    out_data_d  = Rd_Data;
                    out_index_d = rd_index_q;
                    out_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
`else
                out_data_d  = Rd_Data;
                out_index_d = rd_index_q;
                out_valid_d = 1'b1;
                state_d     = S_PRESENT;
`endif
            end
            S_PRESENT: begin
                // Out_Data/Out_Index are only ever loaded in FETCH, so they stay put while stalled.
                if (out_valid_q && Out_Ready) begin
                    word_count_d = word_count_q + CNT_ONE;
                    out_valid_d  = 1'b0;
                    if (out_index_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_index_d = out_index_q + IDX_ONE;
                        state_d    = S_FETCH;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; synchronous reset discards any pending word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            rd_index_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_index_q   <= rd_index_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
        end
    end

    assign Rd_Index   = rd_index_q;
    assign Out_Valid  = out_valid_q;
    assign Out_Data   = out_data_q;
    assign Out_Index  = out_index_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Word_Count = word_count_q;

endmodule

// File: tb/tb_reg_bank_scan_reader.sv
// Directed bench for reg_bank_scan_reader: full scans, consumer stall, ignored restart, mid-scan reset, zero handling.
module tb_reg_bank_scan_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  Rd_Index;
    logic [15:0] Rd_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Out_Data;
    logic [3:0]  Out_Index;
    logic        Busy;
    logic        Done;
    logic [4:0]  Word_Count;

    logic [15:0] bank [16];

    int checks = 0;
    int errors = 0;

    int hs_idx  [$];
    int hs_data [$];
    int hs_cyc  [$];
    int done_n;
    int done_c;

    always #5 Clk = ~Clk;

    assign Rd_Data = bank[Rd_Index];

    reg_bank_scan_reader #(.DEPTH(16), .WIDTH(16), .IDX_W(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Rd_Index   (Rd_Index),
        .Rd_Data    (Rd_Data),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Data   (Out_Data),
        .Out_Index  (Out_Index),
        .Busy       (Busy),
        .Done       (Done),
        .Word_Count (Word_Count)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) bank[i] = 16'hA000 + 16'(i);
    endtask

    // Cycle 0 carries Start; cycle c (1..ncyc) is observed at its falling edge.
    task automatic run(input int stall, input int restart_at, input int reset_at, input int ncyc);
        hs_idx.delete();
        hs_data.delete();
        hs_cyc.delete();
        done_n = 0;
        done_c = 0;
        Start = 1'b1;
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            Start     = (c == restart_at);
            Reset     = (c == reset_at);
            Out_Ready = !((stall != 0 && c >= 8 && c <= 12) || c == reset_at);
            @(negedge Clk);
            if (c == 1) begin
                chk("busy_c1", Busy, 1);
                chk("wc_clear", Word_Count, 0);
            end
            if (stall != 0 && c >= 8 && c <= 12) begin
                chk("stall_valid", Out_Valid, 1);
                chk("stall_data", Out_Data, 16'hA003);
                chk("stall_index", Out_Index, 3);
            end
            if (reset_at != 0 && c == reset_at) begin
                chk("rst_pend_valid", Out_Valid, 1);
                chk("rst_pend_index", Out_Index, 7);
            end
            if (reset_at != 0 && c == reset_at + 1) begin
                chk("rst_busy", Busy, 0);
                chk("rst_valid", Out_Valid, 0);
                chk("rst_wc", Word_Count, 0);
                chk("rst_rdidx", Rd_Index, 0);
                chk("rst_done", Done, 0);
            end
            if (Out_Valid && Out_Ready) begin
                hs_idx.push_back(int'(Out_Index));
                hs_data.push_back(int'(Out_Data));
                hs_cyc.push_back(c);
            end
            if (Done) begin
                done_n++;
                done_c = c;
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        Reset = 1'b0;
        Out_Ready = 1'b1;
    endtask

    // Full 16-word sequence against the bench bank image, optionally with the word-3 stall.
    task automatic check_full(input string tag, input int stall);
        int exp_cyc;
        chk({tag, "_hs_count"}, hs_idx.size(), 16);
        for (int k = 0; k < hs_idx.size() && k < 16; k++) begin
            exp_cyc = (stall != 0 && k >= 4) ? 7 + 2 * k : 2 + 2 * k;
            if (stall != 0 && k == 3) exp_cyc = 13;
            chk({tag, "_idx"}, hs_idx[k], k);
            chk({tag, "_data"}, hs_data[k], {16'h0000, bank[k]});
            chk({tag, "_cyc"}, hs_cyc[k], exp_cyc);
        end
        chk({tag, "_done_n"}, done_n, 1);
        chk({tag, "_done_c"}, done_c, (stall != 0) ? 38 : 33);
        chk({tag, "_wc"}, Word_Count, 16);
        chk({tag, "_busy_end"}, Busy, 0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Out_Ready = 1'b0;
        fill_ramp();
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset_rdidx", Rd_Index, 0);
        chk("reset_valid", Out_Valid, 0);
        chk("reset_data", Out_Data, 0);
        chk("reset_index", Out_Index, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_wc", Word_Count, 0);
        @(posedge Clk); #1;

        // Ready tied high, ramp bank.
        run(0, 0, 0, 40);
        check_full("full", 0);

        // Consumer stalls word 3 for 5 cycles.
        run(1, 0, 0, 45);
        check_full("stall", 1);

        // Start pulsed at cycle 10 must not restart the scan.
        run(0, 10, 0, 40);
        check_full("restart", 0);

        // Reset while word 7 is pending.
        run(0, 0, 16, 30);
        chk("rst_hs_count", hs_idx.size(), 7);
        chk("rst_no_done", done_n, 0);
        chk("rst_idle_busy", Busy, 0);

        run(0, 0, 0, 40);
        check_full("rescan", 0);

`ifdef SCAN_SKIP_ZERO_EN
        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;
        bank[2]  = 16'h1234;
        bank[9]  = 16'h5678;
        bank[15] = 16'h9ABC;
        run(0, 0, 0, 30);
        chk("skip_hs_count", hs_idx.size(), 3);
        if (hs_idx.size() == 3) begin
            chk("skip_idx0", hs_idx[0], 2);
            chk("skip_idx1", hs_idx[1], 9);
            chk("skip_idx2", hs_idx[2], 15);
            chk("skip_data2", hs_data[2], 32'h9ABC);
        end
        chk("skip_done_n", done_n, 1);
        chk("skip_done_c", done_c, 20);
        chk("skip_wc", Word_Count, 3);

        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;
        run(0, 0, 0, 25);
        chk("zero_hs_count", hs_idx.size(), 0);
        chk("zero_done_n", done_n, 1);
        chk("zero_done_c", done_c, 17);
        chk("zero_wc", Word_Count, 0);
`else
        // Zero entries are presented like any other word.
        fill_ramp();
        bank[5] = 16'h0000;
        run(0, 0, 0, 40);
        check_full("zeros", 0);
        if (hs_data.size() > 5) chk("zeros_word5", hs_data[5], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_scan_reader.md
Name: reg_bank_scan_reader

Overview:
Read-side companion to the 16 x 16-bit indexed register bank. On a Start pulse it walks indices 0..DEPTH-1 through the bank's combinational read port. Each word is presented with its index on a valid/ready stream to a downstream consumer, such as the sprite/platform draw logic. The block signals completion and reports how many words it emitted.

Parameters:
- DEPTH, 16, number of bank entries scanned.
- WIDTH, 16, data width of each entry.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= DEPTH.

Ports:
- Clk  in  1  system clock. One clock domain; all logic on posedge Clk.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle request to begin a scan. Sampled only in IDLE.
- Rd_Index  out  IDX_W  index driven to the bank read port.
- Rd_Data  in  WIDTH  bank word at Rd_Index. Combinational, valid in the same cycle.
- Out_Valid  out  1  Out_Data/Out_Index hold a word.
- Out_Ready  in  1  consumer accepts the word when Out_Valid && Out_Ready.
- Out_Data  out  WIDTH  captured word.
- Out_Index  out  IDX_W  index of the captured word.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse when a scan completes.
- Word_Count  out  IDX_W+1  words emitted in the current or last scan.

Behaviour:
- Reset values: state=IDLE; Rd_Index=0, Out_Valid=0, Out_Data=0, Out_Index=0, Busy=0, Done=0, Word_Count=0.
- States and transitions:
  - IDLE: when Start=1, clear Word_Count, set Rd_Index=0, go to FETCH.
  - FETCH (one cycle): capture Rd_Data into Out_Data and Rd_Index into Out_Index, set Out_Valid=1, go to PRESENT.
  - PRESENT: hold Out_Valid, Out_Data and Out_Index stable until a handshake (Out_Valid && Out_Ready).
    - On handshake, Word_Count increments.
    - If Out_Index == DEPTH-1: Out_Valid=0, go to DONE.
    - Otherwise: Rd_Index <= Out_Index+1, Out_Valid=0, go to FETCH.
  - DONE (one cycle): Done=1, then IDLE. Word_Count holds its value until the next Start.
- Latency:
  - First Out_Valid is asserted 2 cycles after Start is sampled.
  - With Out_Ready tied high, words issue every 2 cycles.
  - A full 16-entry scan takes 33 cycles from Start to the Done pulse.
- Out_Valid never drops without a handshake, except on Reset.
- Start is ignored while Busy=1. A Start in the same cycle as Done is also ignored.
- Out_Ready held high while Out_Valid=0 has no effect.
- Rd_Index never exceeds DEPTH-1. There is no wrap to 0 inside a scan.
- Reset mid-scan: on the next edge, return to IDLE with all outputs at reset values. The pending word is discarded and Done is not pulsed.
- Bank writes during a scan are allowed. The word captured in FETCH is the value visible in that cycle.

Optional Feature:
- Macro: SCAN_SKIP_ZERO_EN.
- Defined: FETCH checks Rd_Data == 0 (the bank reset value, meaning an empty slot).
  - A zero word is not presented. Rd_Index increments and the block stays in FETCH, costing one cycle per skipped entry.
  - A zero at index DEPTH-1 goes directly to DONE.
  - An all-zero bank produces no Out_Valid. Done pulses 17 cycles after Start, with Word_Count=0.
- Undefined: every entry is presented, including zeros, and Word_Count=DEPTH at completion.

Test Plan:
- Bank preloaded with entry i = 16'hA000+i, Out_Ready=1, Start pulse -> 16 handshakes with Out_Index 0..15 and data A000..A00F in order. Done pulses once, 33 cycles after Start. Word_Count=16.
- Out_Ready low for 5 cycles while word 3 (16'hA003) is presented -> Out_Valid, Out_Data=A003 and Out_Index=3 stay stable all 5 cycles. Word 4 follows the handshake by exactly 2 cycles.
- Start pulsed again at cycle 10 of a scan -> no restart; the index sequence is unchanged and there is a single Done.
- Reset asserted while Out_Index=7 is pending -> next cycle Busy=0, Out_Valid=0, Word_Count=0, no Done. A following Start rescans from index 0.
- With SCAN_SKIP_ZERO_EN, bank nonzero only at indices 2, 9 and 15 -> exactly 3 words are presented (indices 2, 9, 15), then Done with Word_Count=3.
- With SCAN_SKIP_ZERO_EN, all-zero bank -> no Out_Valid, Done 17 cycles after Start, Word_Count=0.
